// File: rtl/flopenr_pipe.sv
// -----------------------------------------------------------------------------
// flopenr_pipe
//
// Purpose:
//   Parametrised DEPTH-stage enabled pipeline register with per-stage valid
//   tags, a synchronous flush and a saturating fill counter. It is meant to be
//   used as a stall-aware delay line between CPU pipeline stages, for example
//   to carry delayed writeback tags or branch-prediction metadata alongside
//   the instruction they belong to.
//
// Parameters:
//   WIDTH        data width in bits
//   DEPTH        number of stages (>= 1); latency measured in enabled cycles
//   RESET_VALUE  value held by every data stage after reset or a data-clearing
//                flush
//   CLR_DATA     1: clr also loads RESET_VALUE into the data stages
//                0: clr only clears the valid tags, data is held
//   BUBBLE_ZERO  1: stage 0 stores RESET_VALUE instead of d when d_valid = 0
//
// Ports:
//   clk          in   clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   en           in   advance the pipeline (0 = stall, every register holds)
//   clr          in   synchronous flush, takes priority over en
//   d            in   data into stage 0
//   d_valid      in   valid tag travelling with d
//   q            out  data from the last stage (DEPTH-1)
//   q_valid      out  valid tag of the last stage
//   stage_valid  out  valid tag of every stage, bit 0 = newest
//   fill_cnt     out  enabled advances since reset/clr, saturates at DEPTH
//   primed       out  fill_cnt == DEPTH
// -----------------------------------------------------------------------------
module flopenr_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CLR_DATA    = 1'b1,
  parameter bit               BUBBLE_ZERO = 1'b0
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
  output logic                         primed
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  // Current contents of every stage, gathered from the per-stage flops so the
  // next stage and the outputs can pick them up by index.
  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_valid;

  // Data actually presented to stage 0.
  logic [WIDTH-1:0]            w_head_data;

  // ---------------------------------------------------------------------------
  // Stage-0 input selection
  // ---------------------------------------------------------------------------
  // With bubble zeroing the mux selects a constant whenever the tag is low,
  // so garbage (including X) on d for an invalid slot never enters the pipe.
  generate
    if (BUBBLE_ZERO) begin : g_bubble_zero
      assign w_head_data = d_valid ? d : RESET_VALUE;
    end else begin : g_bubble_pass
      assign w_head_data = d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] w_src_data;
      logic             w_src_valid;
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      if (gi == 0) begin : g_head
        assign w_src_data  = w_head_data;
        assign w_src_valid = d_valid;
      end else begin : g_body
        assign w_src_data  = w_data[gi-1];
        assign w_src_valid = w_valid[gi-1];
      end

      // Priority: asynchronous reset, then flush, then advance, else hold.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_data  <= RESET_VALUE;
          r_valid <= 1'b0;
        end else if (clr) begin
          r_valid <= 1'b0;
          if (CLR_DATA) begin
            r_data <= RESET_VALUE;
          end
        end else if (en) begin
          r_data  <= w_src_data;
          r_valid <= w_src_valid;
        end
      end

      assign w_data[gi]  = r_data;
      assign w_valid[gi] = r_valid;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fill counter
  // ---------------------------------------------------------------------------
  // Counts enabled edges rather than valid entries: once it reaches DEPTH
  // every stage has been written since the last reset/flush, bubbles included.
  logic [CW-1:0] r_fill;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fill <= '0;
    end else if (clr) begin
      r_fill <= '0;
    end else if (en && (r_fill != FILL_MAX)) begin
      r_fill <= r_fill + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign q           = w_data[DEPTH-1];
  assign q_valid     = w_valid[DEPTH-1];
  assign stage_valid = w_valid;
  assign fill_cnt    = r_fill;
  assign primed      = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_flopenr_pipe.sv
module tb_flopenr_pipe;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en;
  logic       clr;
  logic [7:0] d;
  logic       d_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u3: DEPTH=3, reset value 0
  logic [7:0] q3;  logic qv3;  logic [2:0] sv3;  logic [1:0] fc3;  logic pr3;
  // u2: DEPTH=2, no bubble zeroing
  logic [7:0] q2;  logic qv2;  logic [1:0] sv2;  logic [1:0] fc2;  logic pr2;
  // u4c: DEPTH=4, reset value 5A, flush clears data
  logic [7:0] q4c; logic qv4c; logic [3:0] sv4c; logic [2:0] fc4c; logic pr4c;
  // u4n: DEPTH=4, reset value 5A, flush keeps data
  logic [7:0] q4n; logic qv4n; logic [3:0] sv4n; logic [2:0] fc4n; logic pr4n;
  // ubz: DEPTH=2, bubble zeroing
  logic [7:0] qbz; logic qvbz; logic [1:0] svbz; logic [1:0] fcbz; logic prbz;
  // u1: DEPTH=1
  logic [7:0] q1;  logic qv1;  logic [0:0] sv1;  logic [0:0] fc1;  logic pr1;

  flopenr_pipe #(.WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q3), .q_valid(qv3), .stage_valid(sv3), .fill_cnt(fc3), .primed(pr3));

  flopenr_pipe #(.WIDTH(8), .DEPTH(2), .BUBBLE_ZERO(1'b0)) u2 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q2), .q_valid(qv2), .stage_valid(sv2), .fill_cnt(fc2), .primed(pr2));

  flopenr_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A), .CLR_DATA(1'b1)) u4c (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q4c), .q_valid(qv4c), .stage_valid(sv4c), .fill_cnt(fc4c), .primed(pr4c));

  flopenr_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A), .CLR_DATA(1'b0)) u4n (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q4n), .q_valid(qv4n), .stage_valid(sv4n), .fill_cnt(fc4n), .primed(pr4n));

  flopenr_pipe #(.WIDTH(8), .DEPTH(2), .BUBBLE_ZERO(1'b1)) ubz (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(qbz), .q_valid(qvbz), .stage_valid(svbz), .fill_cnt(fcbz), .primed(prbz));

  flopenr_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .stage_valid(sv1), .fill_cnt(fc1), .primed(pr1));

  // One rising edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q4c  [4] = '{8'h5A, 8'h5A, 8'h5A, 8'h31};
  logic       exp_qv4c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] exp_q4n  [4] = '{8'h04, 8'hA5, 8'h22, 8'h31};

  initial begin
    n_rst = 1'b0; en = 1'b0; clr = 1'b0; d = 8'h00; d_valid = 1'b0;

    // Reset state, sampled after edges with reset held low
    tick(); tick();
    check("rst_q3", q3, 0);        check("rst_qv3", qv3, 0);
    check("rst_fc3", fc3, 0);      check("rst_pr3", pr3, 0);
    check("rst_q4c", q4c, 8'h5A);  check("rst_q4n", q4n, 8'h5A);
    check("rst_sv4c", sv4c, 0);
    n_rst = 1'b1;

    // Latency through DEPTH=3, DEPTH=1 follows after one edge
    en = 1'b1; d_valid = 1'b1;
    d = 8'h01; tick();
    check("lat_e1_q3", q3, 0);     check("lat_e1_qv3", qv3, 0);
    check("lat_e1_fc3", fc3, 1);   check("lat_e1_pr3", pr3, 0);
    check("d1_e1_q1", q1, 8'h01);  check("d1_e1_qv1", qv1, 1);
    check("d1_e1_sv1", sv1, 1);    check("d1_e1_fc1", fc1, 1);
    check("d1_e1_pr1", pr1, 1);
    d = 8'h02; tick();
    check("lat_e2_q3", q3, 0);     check("lat_e2_qv3", qv3, 0);
    check("lat_e2_sv3", sv3, 3'b011);
    d = 8'h03; tick();
    check("lat_e3_q3", q3, 8'h01); check("lat_e3_qv3", qv3, 1);
    check("lat_e3_pr3", pr3, 1);   check("lat_e3_fc3", fc3, 3);
    d = 8'h04; tick();
    check("lat_e4_q3", q3, 8'h02); check("lat_e4_qv3", qv3, 1);
    check("lat_e4_fc3", fc3, 3);

    // Stall on DEPTH=2
    d = 8'hA5; tick();
    check("stall_load_q2", q2, 8'h04);
    check("stall_load_sv2", sv2, 2'b11);
    en = 1'b0; d = 8'h11; d_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d_q2", k), q2, 8'h04);
      check($sformatf("stall%0d_sv2", k), sv2, 2'b11);
      check($sformatf("stall%0d_fc2", k), fc2, 2);
    end
    en = 1'b1; d = 8'h22; d_valid = 1'b1; tick();
    check("stall_out_q2", q2, 8'hA5); check("stall_out_qv2", qv2, 1);

    // Flush on primed DEPTH=4 pipes, stages hold 22,A5,04,03
    check("pre_clr_q4c", q4c, 8'h03); check("pre_clr_pr4c", pr4c, 1);
    check("pre_clr_fc4c", fc4c, 4);   check("pre_clr_sv4c", sv4c, 4'hF);
    clr = 1'b1; d = 8'h77; tick();
    clr = 1'b0;
    check("clr_q4c", q4c, 8'h5A);  check("clr_qv4c", qv4c, 0);
    check("clr_sv4c", sv4c, 0);    check("clr_fc4c", fc4c, 0);
    check("clr_pr4c", pr4c, 0);
    check("clr_q4n", q4n, 8'h03);  check("clr_qv4n", qv4n, 0);
    check("clr_sv4n", sv4n, 0);    check("clr_fc4n", fc4n, 0);
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h31 + k); tick();
      check($sformatf("refill%0d_q4c", k), q4c, exp_q4c[k]);
      check($sformatf("refill%0d_qv4c", k), qv4c, exp_qv4c[k]);
      check($sformatf("refill%0d_fc4c", k), fc4c, k + 1);
      check($sformatf("refill%0d_q4n", k), q4n, exp_q4n[k]);
      check($sformatf("refill%0d_qv4n", k), qv4n, exp_qv4c[k]);
    end
    check("refill_pr4n", pr4n, 1);

    // Bubbles: FF with d_valid=0, then X with d_valid=0
    d = 8'hFF; d_valid = 1'b0; tick();
    d = 8'hxx; tick();
    check("bub_ff_qbz", qbz, 8'h00);  check("bub_ff_qvbz", qvbz, 0);
    check("bub_ff_q2", q2, 8'hFF);    check("bub_ff_qv2", qv2, 0);
    d = 8'h10; d_valid = 1'b1; tick();
    check("bub_x_qbz", qbz, 8'h00);   check("bub_x_qvbz", qvbz, 0);
    check("bub_x_svbz", svbz, 2'b01);
    d = 8'h11; tick();
    check("bub_v_qbz", qbz, 8'h10);   check("bub_v_qvbz", qvbz, 1);
    check("bub_v_svbz", svbz, 2'b11); check("bub_v_fcbz", fcbz, 2);
    check("bub_v_prbz", prbz, 1);

    // Async reset between edges on a full DEPTH=3 pipe
    d = 8'h41; tick(); d = 8'h42; tick(); d = 8'h43; tick();
    check("full_sv3", sv3, 3'b111);   check("full_q3", q3, 8'h41);
    #2 n_rst = 1'b0;
    #1;
    check("arst_q3", q3, 0);          check("arst_sv3", sv3, 0);
    check("arst_fc3", fc3, 0);        check("arst_pr3", pr3, 0);
    check("arst_q4c", q4c, 8'h5A);    check("arst_sv4c", sv4c, 0);
    #1 n_rst = 1'b1;
    d = 8'h51; tick();
    check("arst_e1_sv3", sv3, 3'b001); check("arst_e1_q3", q3, 0);
    check("arst_e1_fc3", fc3, 1);
    d = 8'h52; tick(); d = 8'h53; tick();
    check("arst_e3_q3", q3, 8'h51);   check("arst_e3_qv3", qv3, 1);
    check("arst_e3_pr3", pr3, 1);

    // Saturation of fill_cnt on DEPTH=2
    clr = 1'b1; tick(); clr = 1'b0;
    check("sat_clr_fc2", fc2, 0);
    for (int k = 0; k < 10; k++) begin
      d = 8'(k); tick();
      check($sformatf("sat%0d_fc2", k), fc2, (k + 1 < 2) ? k + 1 : 2);
    end
    check("sat_pr2", pr2, 1);

    // fill_cnt holds through a stall when not yet saturated
    clr = 1'b1; tick(); clr = 1'b0;
    d = 8'h60; tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold%0d_fc2", k), fc2, 1);
      check($sformatf("hold%0d_sv2", k), sv2, 2'b01);
      check($sformatf("hold%0d_pr2", k), pr2, 0);
    end

    // DEPTH=1 follows d one enabled edge later and holds on stall
    en = 1'b1; d = 8'h61; tick();
    check("d1_q1_61", q1, 8'h61);
    d = 8'h62; tick();
    check("d1_q1_62", q1, 8'h62);
    en = 1'b0; d = 8'h63; tick();
    check("d1_stall_q1", q1, 8'h62);  check("d1_stall_qv1", qv1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
